// File: rtl/mac_seq.sv
// -----------------------------------------------------------------------------
// mac_seq
//
// Vector sequencer placed directly upstream of a multiply-accumulate unit.
// It clears the MAC, streams exactly LEN signed (w, x) operand pairs into it
// through registered w/x/en lines, captures the final accumulator value and
// presents it as a single result beat on a valid/ready output.
//
// Ports:
//   clk        in   1        clock, all state updates on rising edge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        sequencer can accept a pair (ACCUM only)
//   in_w       in   WIDTH    signed weight
//   in_x       in   WIDTH    signed activation
//   mac_rst    out  1        to MAC rst (reset or CLEAR state)
//   mac_en     out  1        to MAC en, registered
//   mac_w      out  WIDTH    to MAC w, registered
//   mac_x      out  WIDTH    to MAC x, registered
//   mac_out    in   2*WIDTH  MAC accumulator, signed
//   res_valid  out  1        result valid
//   res_ready  in   1        consumer accepts result
//   res_data   out  2*WIDTH  signed dot-product result
// -----------------------------------------------------------------------------
module mac_seq #(
  parameter int WIDTH = 8,
  parameter int LEN   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_w,
  input  logic [WIDTH-1:0]     in_x,
  output logic                 mac_rst,
  output logic                 mac_en,
  output logic [WIDTH-1:0]     mac_w,
  output logic [WIDTH-1:0]     mac_x,
  input  logic [2*WIDTH-1:0]   mac_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [2:0] {
    CLEAR,
    ACCUM,
    DRAIN,
    CAPTURE,
    HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 mac_en_q, mac_en_d;
  logic [WIDTH-1:0]     mac_w_q, mac_w_d;
  logic [WIDTH-1:0]     mac_x_q, mac_x_d;
  logic                 res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0]   res_data_q, res_data_d;

  // Next-state and datapath logic. mac_en defaults low so every cycle that
  // does not accept a pair becomes a bubble; w/x hold their last value.
  // DRAIN exists because the MAC only absorbs the final pair one edge after
  // it is accepted, and CAPTURE samples the accumulator one edge after that.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mac_en_d    = 1'b0;
    mac_w_d     = mac_w_q;
    mac_x_d     = mac_x_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    unique case (state_q)
      CLEAR: begin
        state_d = ACCUM;
      end

      ACCUM: begin
        if (in_valid) begin
          mac_w_d  = in_w;
          mac_x_d  = in_x;
          mac_en_d = 1'b1;
          if (count_q == LAST) begin
            count_d = '0;
            state_d = DRAIN;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end

      DRAIN: begin
        state_d = CAPTURE;
      end

      CAPTURE: begin
        res_data_d  = mac_out;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end

      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = CLEAR;
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // State register. Reset discards any partial vector or pending result;
  // the FSM restarts in CLEAR so the MAC is cleared before new pairs flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      count_q     <= '0;
      mac_en_q    <= 1'b0;
      mac_w_q     <= '0;
      mac_x_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mac_en_q    <= mac_en_d;
      mac_w_q     <= mac_w_d;
      mac_x_q     <= mac_x_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // mac_rst follows rst directly so the MAC is held cleared during reset,
  // even before the state register has settled into CLEAR.
  always_comb begin
    mac_rst  = rst | (state_q == CLEAR);
    in_ready = (state_q == ACCUM);
  end

  assign mac_en    = mac_en_q;
  assign mac_w     = mac_w_q;
  assign mac_x     = mac_x_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_seq
//
// Directed bench for mac_seq. A behavioural MAC (clear has priority over
// enable, sum wraps at 16 bits) closes the loop. One instance runs with
// LEN=4, and a second instance runs with LEN=1.
// -----------------------------------------------------------------------------
module tb_mac_seq;

  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_w;
  logic [W-1:0]      in_x;
  logic              mac_rst;
  logic              mac_en;
  logic [W-1:0]      mac_w;
  logic [W-1:0]      mac_x;
  logic [2*W-1:0]    mac_out;
  logic              res_valid;
  logic              res_ready;
  logic [2*W-1:0]    res_data;

  // Signals for the LEN=1 instance
  logic              in_valid1;
  logic              in_ready1;
  logic [W-1:0]      in_w1;
  logic [W-1:0]      in_x1;
  logic              mac_rst1;
  logic              mac_en1;
  logic [W-1:0]      mac_w1;
  logic [W-1:0]      mac_x1;
  logic [2*W-1:0]    mac_out1;
  logic              res_valid1;
  logic              res_ready1;
  logic [2*W-1:0]    res_data1;

  logic [2*W-1:0]    acc;
  logic [2*W-1:0]    acc1;

  int tests_run = 0;
  int tests_failed = 0;
  int en_count = 0;

  typedef struct packed {
    logic [31:0] ws;
    logic [31:0] xs;
    int          gap;
    int          res;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  mac_seq #(.WIDTH(W), .LEN(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_w      (in_w),
    .in_x      (in_x),
    .mac_rst   (mac_rst),
    .mac_en    (mac_en),
    .mac_w     (mac_w),
    .mac_x     (mac_x),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  mac_seq #(.WIDTH(W), .LEN(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_w      (in_w1),
    .in_x      (in_x1),
    .mac_rst   (mac_rst1),
    .mac_en    (mac_en1),
    .mac_w     (mac_w1),
    .mac_x     (mac_x1),
    .mac_out   (mac_out1),
    .res_valid (res_valid1),
    .res_ready (res_ready1),
    .res_data  (res_data1)
  );

  // Behavioural MAC: 8x8 signed product, 16-bit wrapping accumulator
  function automatic logic [15:0] mul16(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return sa * sb;
  endfunction

  always @(posedge clk) begin
    if (mac_rst)     acc <= '0;
    else if (mac_en) acc <= acc + mul16(mac_w, mac_x);
    if (mac_rst1)     acc1 <= '0;
    else if (mac_en1) acc1 <= acc1 + mul16(mac_w1, mac_x1);
  end

  assign mac_out  = acc;
  assign mac_out1 = acc1;

  function automatic vec_t mkVec(input int w0, input int x0, input int w1, input int x1,
                                 input int w2, input int x2, input int w3, input int x3,
                                 input int gap, input int res);
    vec_t v;
    v.ws  = {w3[7:0], w2[7:0], w1[7:0], w0[7:0]};
    v.xs  = {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
    v.gap = gap;
    v.res = res;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge; also tallies mac_en
  task automatic step();
    @(posedge clk);
    #1;
    if (mac_en) en_count++;
  endtask

  // Present one pair and wait (bounded) for the edge that accepts it
  task automatic feedPair(input int w, input int x);
    bit rdy;
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_w = w[7:0];
    in_x = x[7:0];
    for (int t = 0; t < 20; t++) begin
      rdy = in_ready;
      step();
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    checkOutput("pair accepted", int'(accepted), 1);
    checkOutput("mac_en after accept", int'(mac_en), 1);
    checkOutput("mac_w after accept", int'($signed(mac_w)), w);
    checkOutput("mac_x after accept", int'($signed(mac_x)), x);
  endtask

  // Feed a whole vector with optional gaps and check the result beat timing:
  // res_valid low at E and E+1, high with the right data after E+2
  task automatic applyStimulus(input vec_t v, input bit ready);
    res_ready = ready;
    en_count = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < v.gap; g++) step();
      end
      feedPair(int'($signed(v.ws[i*8 +: 8])), int'($signed(v.xs[i*8 +: 8])));
    end
    checkOutput("res_valid low after last accept", int'(res_valid), 0);
    step();
    checkOutput("res_valid low in DRAIN", int'(res_valid), 0);
    checkOutput("mac_en low after DRAIN", int'(mac_en), 0);
    step();
    checkOutput("res_valid high after E+2", int'(res_valid), 1);
    checkOutput("res_data", int'($signed(res_data)), v.res);
  endtask

  // Completes a result handshake with res_ready high and checks the return to CLEAR
  task automatic finishResult();
    step();
    checkOutput("res_valid one cycle", int'(res_valid), 0);
    checkOutput("mac_rst in CLEAR", int'(mac_rst), 1);
    checkOutput("in_ready low in CLEAR", int'(in_ready), 0);
    checkOutput("mac_en high cycles", en_count, 4);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_w = '0;
    in_x = '0;
    res_ready = 1'b0;
    in_valid1 = 1'b0;
    in_w1 = '0;
    in_x1 = '0;
    res_ready1 = 1'b1;

    vecs[0] = mkVec(-3, 2, 5, -4, 6, -8, 1, 1, 0, -73);
    vecs[1] = mkVec(-3, 2, 5, -4, 6, -8, 1, 1, 2, -73);
    vecs[2] = mkVec(127, 127, 127, 127, 127, 127, 127, 127, 0, -1020);
    vecs[3] = mkVec(2, 3, 2, 3, 2, 3, 2, 3, 0, 24);
    vecs[4] = mkVec(-128, -128, -128, -128, -128, -128, -128, -128, 1, 0);
    vecs[5] = mkVec(-1, 1, 2, 2, -3, 3, 4, 4, 3, 10);

    // Reset values while rst is held for three cycles
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("reset res_valid", int'(res_valid), 0);
      checkOutput("reset res_data", int'(res_data), 0);
      checkOutput("reset mac_en", int'(mac_en), 0);
      checkOutput("reset mac_w", int'(mac_w), 0);
      checkOutput("reset mac_rst", int'(mac_rst), 1);
      checkOutput("reset in_ready", int'(in_ready), 0);
    end
    rst = 1'b0;
    #1;
    checkOutput("CLEAR after reset mac_rst", int'(mac_rst), 1);
    checkOutput("CLEAR after reset in_ready", int'(in_ready), 0);
    step();
    checkOutput("ACCUM in_ready", int'(in_ready), 1);
    checkOutput("ACCUM mac_rst", int'(mac_rst), 0);

    // Table-driven vectors with res_ready held high
    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k], 1'b1);
      finishResult();
    end

    // Backpressure: result held for five cycles, then released
    applyStimulus(vecs[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput("HOLD res_valid", int'(res_valid), 1);
      checkOutput("HOLD res_data", int'($signed(res_data)), -73);
      checkOutput("HOLD in_ready", int'(in_ready), 0);
    end
    res_ready = 1'b1;
    en_count = 4;
    finishResult();
    applyStimulus(vecs[3], 1'b1);
    finishResult();

    // Reset while a result is pending in HOLD
    applyStimulus(vecs[2], 1'b0);
    step();
    rst = 1'b1;
    step();
    checkOutput("reset in HOLD res_valid", int'(res_valid), 0);
    checkOutput("reset in HOLD res_data", int'(res_data), 0);
    checkOutput("reset in HOLD in_ready", int'(in_ready), 0);
    rst = 1'b0;
    step();

    // Reset mid-vector after two pairs of (10,10)
    res_ready = 1'b1;
    feedPair(10, 10);
    feedPair(10, 10);
    rst = 1'b1;
    step();
    checkOutput("mid reset mac_rst", int'(mac_rst), 1);
    checkOutput("mid reset mac_en", int'(mac_en), 0);
    checkOutput("mid reset in_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    checkOutput("mid reset CLEAR in_ready", int'(in_ready), 0);
    checkOutput("mid reset CLEAR mac_rst", int'(mac_rst), 1);
    step();
    checkOutput("mid reset in_ready rises", int'(in_ready), 1);
    checkOutput("mid reset no result", int'(res_valid), 0);
    applyStimulus(mkVec(1, 1, 1, 1, 1, 1, 1, 1, 0, 4), 1'b1);
    finishResult();

    // LEN=1: the single acceptance goes straight to DRAIN
    checkOutput("len1 in_ready", int'(in_ready1), 1);
    in_valid1 = 1'b1;
    in_w1 = 8'd7;
    in_x1 = 8'hF7;
    step();
    in_valid1 = 1'b0;
    checkOutput("len1 mac_en", int'(mac_en1), 1);
    checkOutput("len1 in_ready low in DRAIN", int'(in_ready1), 0);
    step();
    checkOutput("len1 res_valid low in CAPTURE", int'(res_valid1), 0);
    step();
    checkOutput("len1 res_valid", int'(res_valid1), 1);
    checkOutput("len1 res_data", int'($signed(res_data1)), -63);
    step();
    checkOutput("len1 res_valid one cycle", int'(res_valid1), 0);
    checkOutput("len1 mac_rst CLEAR", int'(mac_rst1), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
